prog_delay_timer: RTL and testbench



---
 rtl/prog_delay_timer.sv | 87 ++++++++
 tb/tb_prog_delay_timer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/prog_delay_timer.sv
// Programmable delay/timer with prescaler, one-shot or periodic reload,
// restart/cancel controls and status outputs.
module prog_delay_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             cancel,
  input  logic             mode,
  input  logic [WIDTH-1:0] delay_val,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] reload;
  logic [PW-1:0]    psc;
  logic             mode_r;
  logic             tick;
  logic [WIDTH-1:0] load_val;

  // With no prescaling every clock is a tick
  assign tick = (PRESCALE == 1) ? 1'b1 : (psc == PS_LAST);

  // A zero delay is treated as a one-tick delay
  assign load_val = (delay_val == '0) ? ONE : delay_val;

  assign busy      = (state == RUN);
  assign remaining = cnt;

  // Control FSM: clr > cancel > start > counting
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= '0;
      reload <= '0;
      psc    <= '0;
      mode_r <= 1'b0;
      tc     <= 1'b0;
      done   <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        cnt   <= '0;
        psc   <= '0;
        done  <= 1'b0;
      end else if (start) begin
        reload <= load_val;
        mode_r <= mode;
        cnt    <= load_val;
        psc    <= '0;
        done   <= 1'b0;
        state  <= RUN;
      end else if (state == RUN) begin
        psc <= tick ? '0 : psc + 1'b1;
        if (tick) begin
          if (cnt == ONE) begin
            tc <= 1'b1;
            if (mode_r) begin
              cnt <= reload;
              psc <= '0;
            end else begin
              cnt   <= '0;
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_delay_timer.sv
// Directed self-checking bench for prog_delay_timer.
// Instance a runs with PRESCALE=1, instance b with PRESCALE=3.
module tb_prog_delay_timer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] delay_val = 4'd0;

  logic       busy_a, tc_a, done_a;
  logic [3:0] rem_a;
  logic       busy_b, tc_b, done_b;
  logic [3:0] rem_b;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prog_delay_timer #(.WIDTH(4), .PRESCALE(1)) dut_a (
    .clk(clk), .clr(clr), .start(start), .cancel(cancel),
    .mode(mode), .delay_val(delay_val),
    .busy(busy_a), .tc(tc_a), .done(done_a), .remaining(rem_a)
  );

  prog_delay_timer #(.WIDTH(4), .PRESCALE(3)) dut_b (
    .clk(clk), .clr(clr), .start(start), .cancel(cancel),
    .mode(mode), .delay_val(delay_val),
    .busy(busy_b), .tc(tc_b), .done(done_b), .remaining(rem_b)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values, no clock edge yet
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_tc", tc_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rem", rem_a, 0);
    check("rst_busy_b", busy_b, 0);
    step();
    clr = 1'b0;
    step();
    check("idle_busy", busy_a, 0);

    // One-shot, delay 5
    start = 1'b1; mode = 1'b0; delay_val = 4'd5;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("os_busy", busy_a, 1);
      check("os_rem", rem_a, 32'(5 - k));
      check("os_tc", tc_a, 0);
      step();
    end
    check("os_tc_fire", tc_a, 1);
    check("os_busy_end", busy_a, 0);
    check("os_done", done_a, 1);
    check("os_rem_end", rem_a, 0);
    step();
    check("os_tc_once", tc_a, 0);
    check("os_done_hold", done_a, 1);

    // Periodic, PRESCALE=3, delay 2; live delay_val change ignored
    start = 1'b1; mode = 1'b1; delay_val = 4'd2;
    step();
    start = 1'b0; delay_val = 4'd7;
    check("per_rem0", rem_b, 2);
    for (int k = 1; k <= 24; k++) begin
      step();
      check("per_tc", tc_b, (k % 6 == 0) ? 1 : 0);
      check("per_busy", busy_b, 1);
      check("per_done", done_b, 0);
      check("per_rem", rem_b, ((k % 6) < 3) ? 2 : 1);
    end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("per_cancel_busy", busy_b, 0);
    check("per_cancel_rem", rem_b, 0);

    // One-shot 8, cancel at remaining 3
    start = 1'b1; mode = 1'b0; delay_val = 4'd8;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("can_pre_rem", rem_a, 3);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("can_busy", busy_a, 0);
    check("can_rem", rem_a, 0);
    check("can_done", done_a, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("can_no_tc", tc_a, 0);
    end
    start = 1'b1; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    check("sc_busy", busy_a, 0);
    check("sc_rem", rem_a, 0);

    // Restart on the terminal edge
    start = 1'b1; mode = 1'b0; delay_val = 4'd4;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("rs_pre_rem", rem_a, 1);
    start = 1'b1; delay_val = 4'd6;
    step();
    start = 1'b0;
    check("rs_tc_sup", tc_a, 0);
    check("rs_busy", busy_a, 1);
    check("rs_rem", rem_a, 6);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("rs_tc", tc_a, (k == 6) ? 1 : 0);
    end
    check("rs_done", done_a, 1);

    // Asynchronous clr mid-count
    start = 1'b1; delay_val = 4'd8;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("clr_pre_rem", rem_a, 5);
    #2 clr = 1'b1;
    #1;
    check("clr_busy", busy_a, 0);
    check("clr_rem", rem_a, 0);
    check("clr_tc", tc_a, 0);
    check("clr_done", done_a, 0);
    #2 clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("clr_idle_tc", tc_a, 0);
      check("clr_idle_busy", busy_a, 0);
    end

    // Zero delay acts as one tick
    start = 1'b1; delay_val = 4'd0;
    step();
    start = 1'b0;
    check("z_rem", rem_a, 1);
    check("z_busy", busy_a, 1);
    step();
    check("z_tc", tc_a, 1);
    check("z_done", done_a, 1);
    check("z_busy_end", busy_a, 0);

    // Maximum delay 15, no wrap
    start = 1'b1; delay_val = 4'd15;
    step();
    start = 1'b0;
    check("max_rem", rem_a, 15);
    for (int k = 1; k <= 15; k++) begin
      step();
      check("max_tc", tc_a, (k == 15) ? 1 : 0);
    end
    check("max_done", done_a, 1);
    check("max_rem_end", rem_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
